// File: rtl/register_scoreboard.sv
// register_scoreboard
// Per-register pending-write counters for the ARM pipeline. A writer that
// issues from ID bumps the count of its destination; writeback or cancel
// brings it back down. ID source operands are reported available only when
// no writer is pending on them.
//
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN
//   When defined, a register with exactly one pending writer that is being
//   written back this cycle (and not re-issued) reports available in the
//   same cycle, adding a combinational path from WB_* to src*_available.
//   When undefined, availability comes purely from the registered counts.

module register_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_en,
    input  logic                        issue_WB_EN,
    input  logic [$clog2(NUM_REGS)-1:0] issue_Dest,
    input  logic                        WB_WB_EN,
    input  logic [$clog2(NUM_REGS)-1:0] WB_Dest,
    input  logic                        cancel_en,
    input  logic [$clog2(NUM_REGS)-1:0] cancel_Dest,
    input  logic [$clog2(NUM_REGS)-1:0] Rn,
    input  logic [$clog2(NUM_REGS)-1:0] Src2,
    input  logic                        Two_src,
    output logic                        src1_available,
    output logic                        src2_available,
    output logic                        busy,
    output logic                        overflow_err,
    output logic                        underflow_err
);

    localparam int IDX_W = $clog2(NUM_REGS);
    // Two extra bits: one of headroom for +1, one for the sign of a -2 result.
    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_CNT = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]        cnt_q [NUM_REGS];
    logic [CNT_W-1:0]        cnt_d [NUM_REGS];
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    unf_q;
    logic                    unf_d;
    logic [NUM_REGS-1:0]     freeVec;
    logic                    busyAny;

    logic                    incHit;
    logic                    wbHit;
    logic                    canHit;
    logic signed [SUM_W-1:0] sum;

    // Next count per register: apply +inc -dec, saturate high, clamp low, and latch errors.
    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        incHit = 1'b0;
        wbHit  = 1'b0;
        canHit = 1'b0;
        sum    = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            incHit = issue_en & issue_WB_EN & (issue_Dest == IDX_W'(r));
            wbHit  = WB_WB_EN & (WB_Dest == IDX_W'(r));
            canHit = cancel_en & (cancel_Dest == IDX_W'(r));
            sum    = $signed({2'b00, cnt_q[r]})
                   + $signed(SUM_W'(incHit))
                   - $signed(SUM_W'(wbHit))
                   - $signed(SUM_W'(canHit));
            if (sum[SUM_W-1]) begin
                cnt_d[r] = '0;
                unf_d    = 1'b1;
            end else if (sum > MAX_CNT) begin
                cnt_d[r] = MAX_CNT[CNT_W-1:0];
                ovf_d    = 1'b1;
            end else begin
                cnt_d[r] = sum[CNT_W-1:0];
            end
        end
    end

    // Counter and sticky error state; reset discards any events in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Per-register "no pending writer" view, optionally releasing on a final writeback.
    always_comb begin
        freeVec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            freeVec[r] = (cnt_q[r] == '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
            if ((cnt_q[r] == CNT_W'(1)) && WB_WB_EN && (WB_Dest == IDX_W'(r))
                && !(issue_en && issue_WB_EN && (issue_Dest == IDX_W'(r)))) begin
                freeVec[r] = 1'b1;
            end
`endif
        end
    end

    // Busy whenever any register still has an in-flight writer.
    always_comb begin
        busyAny = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) begin
                busyAny = 1'b1;
            end
        end
    end

    assign src1_available = freeVec[Rn];
    assign src2_available = !Two_src | freeVec[Src2];
    assign busy           = busyAny;
    assign overflow_err   = ovf_q;
    assign underflow_err  = unf_q;

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Tracks in-flight register writes in the ARM pipeline and reports whether the ID-stage source operands are free of pending writers. It keeps a per-register pending-write counter: incremented when a writing instruction issues from ID, decremented at writeback or cancel. It drives `src1_available` and `src2_available`, which the hazard detection logic consumes as the opposite end of that interface. It sits beside the register file and is clocked with the pipeline registers.

## Interface
- `NUM_REGS`, 16: architectural registers tracked, R0–R15; the index width is 4 bits.
- `CNT_W`, 2: counter width per register; maximum in-flight writers per register is 2^CNT_W − 1 = 3.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `issue_en` input 1: the ID instruction advances to EXE this cycle (not stalled, not flushed).
- `issue_WB_EN` input 1: the issuing instruction writes a register.
- `issue_Dest` input 4: destination of the issuing instruction.
- `WB_WB_EN` input 1: a writeback completes this cycle.
- `WB_Dest` input 4: writeback destination.
- `cancel_en` input 1: an already-issued writer is squashed.
- `cancel_Dest` input 4: destination of the squashed writer.
- `Rn` input 4: ID source 1 index.
- `Src2` input 4: ID source 2 index.
- `Two_src` input 1: the ID instruction reads `Src2`.
- `src1_available` output 1: `Rn` has no pending writer.
- `src2_available` output 1: `Src2` has no pending writer, or `Two_src` = 0.
- `busy` output 1: at least one counter is non-zero.
- `overflow_err` output 1: sticky; an increment was attempted at the maximum count.
- `underflow_err` output 1: sticky; a decrement was attempted at zero.

## Operation
- State: `NUM_REGS` counters of `CNT_W` bits, plus the two sticky error flags.
- Per-cycle deltas for register r:
  - inc = `issue_en & issue_WB_EN & (issue_Dest == r)`
  - dec = `WB_WB_EN & (WB_Dest == r)` + `cancel_en & (cancel_Dest == r)`
  - dec can be 0, 1 or 2.
- Next count = count + inc − dec, computed at CNT_W+2 bits signed.
  - Result > 3: count saturates at 3 and `overflow_err` sets.
  - Result < 0: count clamps at 0 and `underflow_err` sets.
  - Net-zero events, such as an issue and a writeback to the same register in one cycle, leave the count unchanged and raise no error.
- Error flags stay set until `rst`.
- Availability, base behaviour:
  - `src1_available` = (count[`Rn`] == 0).
  - `src2_available` = !`Two_src` | (count[`Src2`] == 0).
  - Both read registered state only.
- `busy` = OR over all counters being non-zero, read from registered state.
- R15 (PC) is tracked like any other register; no special case.

## Timing
- Reset, synchronous:
  - All counters 0.
  - `src1_available` = 1, `src2_available` = 1.
  - `busy` = 0, `overflow_err` = 0, `underflow_err` = 0.
- `rst` asserted mid-operation discards all pending counts at that edge. Events in the same cycle as `rst` are ignored.
- An issue at edge N makes the destination unavailable from cycle N+1 onward.
- A writeback at edge N makes the register available from cycle N+1 onward when its count reaches 0 (base build).
- Outputs are combinational from state plus `Rn`, `Src2` and `Two_src`. There is no combinational path from `issue_*` to the outputs.

## Configuration
- `SCOREBOARD_WB_BYPASS_EN`:
  - Defined: a register whose count is 1, is being written back this cycle (`WB_WB_EN`, `WB_Dest` match), and is not being re-issued this cycle reports available in the same cycle. This adds a combinational path from `WB_*` to `src*_available`.
  - Undefined: availability derives only from registered counts, so there is one extra cycle before release.
  - Counter update behaviour is identical in both builds.

## Test plan
- Reset: hold `rst` 2 cycles.
  - Expect all outputs at reset values.
  - Expect `src1_available` = 1 for every `Rn` 0–15.
- Issue R3 at cycle 1 with `Rn` = 3, then writeback R3 at cycle 4.
  - Expect `src1_available` = 0 in cycles 2–4 and 1 from cycle 5.
  - With bypass, expect 1 already in cycle 4.
- Issue R5 three times, then a 4th issue of R5.
  - Expect the count to hold at 3 and `overflow_err` = 1.
  - Then 3 writebacks → R5 available and `busy` = 0.
- Same cycle: issue R7 and writeback R7 with count = 1.
  - Expect the count to stay 1 and `src1_available` for R7 to stay 0 in both builds.
- `Two_src` = 0 with `Src2` = 9 pending → `src2_available` = 1. Set `Two_src` = 1 → 0.
- Cancel R2 at count 0 → `underflow_err` = 1 and the count stays 0. Then `rst` mid-sequence clears the flag and all counts.
